// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch front end: owns the PC and keeps one word request outstanding to imem.
// Optional IF_PERF_CNT_EN adds saturating stall and fetch counters.

module if_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 64
) (
    input  logic        clk,
    input  logic        rst_i,
    input  logic        hold_i,
    input  logic        redirect_i,
    input  logic [31:0] target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_plus4_o,
    output logic        fetch_stall_o,
    output logic        error_o
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt_o,
    output logic [31:0] fetch_cnt_o
`endif
);

    // state | meaning
    // IDLE  | post-reset, launches the first request next edge
    // FETCH | request outstanding, waiting for imem_ack_i
    // HAVE  | fetched word presented to IF/ID, PC advances or redirects when not held
    typedef enum logic [1:0] {IDLE, FETCH, HAVE} state_t;

    localparam logic [15:0] TO_CNT  = 16'(TIMEOUT);
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    state_t      state_q;
    logic [29:0] pc_q;
    logic [15:0] wait_q;
    logic        unused_tgt_bits;

    // PC is kept word-aligned, so the low target bits are dropped
    assign unused_tgt_bits = ^target_i[1:0];
    assign imem_addr_o     = {pc_q, 2'b00};

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC[31:2];
            instr_o       <= 32'h0;
            pc_plus4_o    <= 32'h0;
            imem_req_o    <= 1'b0;
            fetch_stall_o <= 1'b1;
            error_o       <= 1'b0;
            wait_q        <= 16'h0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q    <= FETCH;
                    imem_req_o <= 1'b1;
                end
                FETCH: begin
                    if (imem_ack_i) begin
                        instr_o       <= imem_data_i;
                        pc_plus4_o    <= {pc_q + 30'd1, 2'b00};
                        state_q       <= HAVE;
                        imem_req_o    <= 1'b0;
                        fetch_stall_o <= 1'b0;
                        wait_q        <= 16'h0;
                    end else if (wait_q != TO_CNT) begin
                        // counter saturates at TIMEOUT; the error flag stays sticky
                        wait_q <= wait_q + 16'd1;
                        if (wait_q == TO_LAST)
                            error_o <= 1'b1;
                    end
                end
                HAVE: begin
                    if (!hold_i) begin
                        pc_q          <= redirect_i ? target_i[31:2] : pc_q + 30'd1;
                        state_q       <= FETCH;
                        imem_req_o    <= 1'b1;
                        fetch_stall_o <= 1'b1;
                    end
                end
                default: begin
                    state_q       <= IDLE;
                    imem_req_o    <= 1'b0;
                    fetch_stall_o <= 1'b1;
                end
            endcase
        end
    end

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst_i) begin
            stall_cnt_o <= 32'h0;
            fetch_cnt_o <= 32'h0;
        end else if (state_q == FETCH) begin
            if (stall_cnt_o != 32'hFFFF_FFFF)
                stall_cnt_o <= stall_cnt_o + 32'd1;
            if (imem_ack_i && fetch_cnt_o != 32'hFFFF_FFFF)
                fetch_cnt_o <= fetch_cnt_o + 32'd1;
        end
    end
`endif

endmodule
